// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides clk down to the pixel rate, scans an
// H_TOTAL x V_TOTAL raster and emits registered sync, blanking, coordinates and
// a per-frame start strobe. Every output comes straight from a flop.
module vga_sync_gen #(
  parameter int unsigned clk_mhz       = 50,
  parameter int unsigned pixel_mhz     = 25,
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned h_front       = 16,
  parameter int unsigned h_sync        = 96,
  parameter int unsigned h_back        = 48,
  parameter int unsigned v_front       = 10,
  parameter int unsigned v_sync        = 2,
  parameter int unsigned v_back        = 33,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           frame_start
);

  localparam int unsigned HTotal = screen_width + h_front + h_sync + h_back;
  localparam int unsigned VTotal = screen_height + v_front + v_sync + v_back;
  localparam int unsigned Ratio  = clk_mhz / pixel_mhz;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast    = HW'(HTotal - 1);
  localparam logic [HW-1:0] HVisEnd  = HW'(screen_width);
  localparam logic [HW-1:0] HSyncBeg = HW'(screen_width + h_front);
  localparam logic [HW-1:0] HSyncEnd = HW'(screen_width + h_front + h_sync);
  localparam logic [VW-1:0] VLast    = VW'(VTotal - 1);
  localparam logic [VW-1:0] VVisEnd  = VW'(screen_height);
  localparam logic [VW-1:0] VSyncBeg = VW'(screen_height + v_front);
  localparam logic [VW-1:0] VSyncEnd = VW'(screen_height + v_front + v_sync);

  // The divider only works for an exact integer clock-to-pixel ratio.
  if ((pixel_mhz == 0) || (clk_mhz < pixel_mhz) || ((clk_mhz % pixel_mhz) != 0)) begin : g_bad_ratio
    $error("vga_sync_gen: clk_mhz / pixel_mhz must be an integer >= 1");
  end

  logic pix_en;

  if (Ratio == 1) begin : g_no_div
    assign pix_en = 1'b1;
  end else begin : g_div
    localparam int unsigned DW = $clog2(Ratio);
    localparam logic [DW-1:0] DLast = DW'(Ratio - 1);

    logic [DW-1:0] div_q, div_d;

    // Free-running divider; wraps at Ratio-1.
    always_comb begin
      div_d = (div_q == DLast) ? '0 : div_q + DW'(1);
    end

    // Divider state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
    end

    assign pix_en = (div_q == DLast);
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Raster position advance: h wraps into a v increment, v wraps at frame end.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  // Raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic visible, hs_act, vs_act, origin;

  // Decode of the current raster position; loaded into the output flops below.
  always_comb begin
    visible = (h_q < HVisEnd) && (v_q < VVisEnd);
    hs_act  = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    vs_act  = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
    origin  = (h_q == '0) && (v_q == '0);
  end

  logic           hsync_q, vsync_q, display_on_q, frame_start_q;
  logic [w_x-1:0] x_q;
  logic [w_y-1:0] y_q;

  // Output registers load once per pixel slot; frame_start drops on the next clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      hsync_q       <= ~hs_act;
      vsync_q       <= ~vs_act;
      display_on_q  <= visible;
      x_q           <= visible ? h_q[w_x-1:0] : '0;
      y_q           <= visible ? v_q[w_y-1:0] : '0;
      frame_start_q <= origin;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the graphics labs. It divides the system clock down to the pixel rate and scans a 640x480 VGA frame. It drives the `x`, `y` and `display_on` inputs of the lab top/game logic, plus `hsync` and `vsync` for the board VGA connector. It also produces a one-clock `frame_start` strobe that game logic uses as its per-frame update tick.

## Interface
- `clk_mhz`, 50: system clock frequency in MHz.
- `pixel_mhz`, 25: pixel rate in MHz. `clk_mhz / pixel_mhz` must be an integer ≥ 1 (elaboration error otherwise).
- `screen_width`, 640: visible pixels per line.
- `screen_height`, 480: visible lines per frame.
- `h_front`, 16; `h_sync`, 96; `h_back`, 48: horizontal porch and sync widths, in pixels.
- `v_front`, 10; `v_sync`, 2; `v_back`, 33: vertical porch and sync widths, in lines.
- `w_x`, `$clog2(screen_width)`; `w_y`, `$clog2(screen_height)`: coordinate widths.
- `clk  input  1`: system clock. All logic is on the rising edge; there is one clock.
- `rst  input  1`: reset, asynchronous, active-high.
- `hsync  output  1`: horizontal sync, active low.
- `vsync  output  1`: vertical sync, active low.
- `display_on  output  1`: high while the current pixel is in the visible area.
- `x  output  w_x`: pixel column; 0 when `display_on`=0.
- `y  output  w_y`: pixel row; 0 when `display_on`=0.
- `frame_start  output  1`: one-clk pulse marking the pixel (0,0) of each frame.

## Operation
- Derived constants: `H_TOTAL = screen_width + h_front + h_sync + h_back` (800); `V_TOTAL = screen_height + v_front + v_sync + v_back` (525); `RATIO = clk_mhz / pixel_mhz` (2).
- Divider counter `div`, range 0..RATIO-1:
  - Increments every clk and wraps at RATIO-1.
  - `pix_en = (div == RATIO-1)`.
  - If RATIO=1, `pix_en` is constantly 1.
- Horizontal counter `h`, range 0..H_TOTAL-1, and vertical counter `v`, range 0..V_TOTAL-1. Both are `$clog2(total)` bits wide.
  - On `pix_en`, `h` increments.
  - When `h == H_TOTAL-1`, `h` goes to 0 and `v` increments.
  - When `v == V_TOTAL-1` and `h` wraps, `v` goes to 0.
- Decode of the current (`h`,`v`):
  - visible = `h < screen_width && v < screen_height`.
  - hsync active when `h` is in [`screen_width+h_front`, `screen_width+h_front+h_sync`), i.e. [656,752).
  - vsync active when `v` is in [`screen_height+v_front`, `screen_height+v_front+v_sync`), i.e. [490,492).
- All outputs are registered and load only on `pix_en` edges, from the decode of the counter values before that edge. The counters advance on the same edge.
  - `x` and `y` are the truncated `h` and `v` when visible, else 0.
  - `hsync` and `vsync` are low when their sync region is active.
- `frame_start` is set on the `pix_en` edge that loads (0,0) and cleared on the next clk edge. When RATIO=1 it is cleared on the next edge unless (0,0) is loaded again, which it cannot be.
- Reset (async assert, any time including mid-line or mid-frame) forces:
  - `div`, `h`, `v` = 0;
  - `hsync` = `vsync` = 1;
  - `display_on` = 0, `x` = `y` = 0, `frame_start` = 0.
- After reset release the scan restarts at (0,0). No partial frame is emitted.

## Timing
- Outputs change only on `pix_en` edges, except the clearing of `frame_start`. Each output value is held for exactly RATIO clks.
- Latency is one pixel slot: the outputs for counter state (`h`,`v`) appear after the edge at which the counter leaves that state.
- First `pix_en` edge after reset release is the RATIO-th clk edge. At that edge, `display_on`=1, `x`=0, `y`=0, `frame_start`=1.
- Line period is `H_TOTAL*RATIO` clks (1600). Frame period is `H_TOTAL*V_TOTAL*RATIO` clks (840000).
- `frame_start` pulses are exactly one frame period apart.
- `hsync` low width is `h_sync*RATIO` clks (192). `vsync` low width is `v_sync` lines (3200 clks).
- `hsync` and `vsync` edges are aligned to `pix_en` edges. No glitches: all outputs come directly from flops.

## Test plan
- **Reset values:** hold `rst`=1 for 5 clks → `hsync`=1, `vsync`=1, `display_on`=0, `x`=0, `y`=0, `frame_start`=0. Release → at the 2nd clk edge, `display_on`=1, (x,y)=(0,0) and `frame_start`=1 for exactly 1 clk.
- **Line scan:** run one line → `x` counts 0..639, each value held 2 clks. `display_on` falls when `x` would be 640. `hsync` goes low for 192 clks starting 1312 clks after `x`=0 first appears (h=656). The next line starts with `y`=1 after 1600 clks.
- **Frame scan:** run two frames → `frame_start` pulses are 840000 clks apart. `y` reaches 479 then `display_on` stays 0 for 45 lines. `vsync` is low for lines 490..491 only.
- **Mid-frame reset:** assert `rst` asynchronously (between edges) at h=300, v=200 → outputs go to reset values immediately without waiting for a clk. After release, the scan restarts at (0,0) with a `frame_start` pulse.
- **RATIO=1 parameterization:** `clk_mhz`=25, `pixel_mhz`=25 → `x` advances every clk, line = 800 clks, frame = 420000 clks, `frame_start` is 1 clk wide.
- **Coordinate bounds:** in all runs, check `x`<640 and `y`<480 whenever `display_on`=1, and `x`=`y`=0 whenever `display_on`=0.
